mem_ls_unit: RTL and testbench

Load/store unit between the datapath's memory stage and `data_mem`. It accepts byte, halfword and word load/store requests and checks their alignment. It drives `data_mem`'s word-wide, big-endian port. Sub-word stores become a two-cycle read-modify-write, and sub-word loads are sign- or zero-extended before a one-cycle response pulse goes back to the datapath.

---
 rtl/mem_ls_unit_pkg.sv | 37 +++
 rtl/ls_lane_align.sv | 55 +++++
 rtl/mem_ls_unit.sv | 115 +++++++++++
 tb/tb_mem_ls_unit.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ls_unit_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states,
// word constants, the latched request record and the alignment rule.
package mem_ls_unit_pkg;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LOAD   = 3'd1;
   localparam logic [2:0] ST_STORE  = 3'd2;
   localparam logic [2:0] ST_RMW_RD = 3'd3;
   localparam logic [2:0] ST_RMW_WR = 3'd4;
   localparam logic [2:0] ST_RESP   = 3'd5;
   localparam logic [2:0] ST_ERR    = 3'd6;

   localparam logic [31:0] WORD_ZERO = 32'h0000_0000;
   localparam logic [31:0] Z         = 32'hzzzz_zzzz;

   typedef struct packed {
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
   } ls_req_t;

   // Halves need an even address, words a word-aligned one; size 2'b11 never passes.
   function automatic logic req_legal(input logic [1:0] size, input logic [1:0] offset);
      case (size)
         SIZE_B:  return 1'b1;
         SIZE_H:  return ~offset[0];
         SIZE_W:  return (offset == 2'b00);
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ls_lane_align.sv
// Big-endian lane steering: extracts and extends a load lane from a memory
// word, and merges right-justified store data into an old word.
module ls_lane_align
   import mem_ls_unit_pkg::*;
(
   input  logic [31:0] i_mem_word,
   input  logic [31:0] i_wdata,
   input  logic [1:0]  i_offset,
   input  logic [1:0]  i_size,
   input  logic        i_signed,
   output logic [31:0] o_load_data,
   output logic [31:0] o_merge_word
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = 8'h00;
      case (i_offset)
         2'd0:    w_byte = i_mem_word[31:24];
         2'd1:    w_byte = i_mem_word[23:16];
         2'd2:    w_byte = i_mem_word[15:8];
         default: w_byte = i_mem_word[7:0];
      endcase
      w_half = i_offset[1] ? i_mem_word[15:0] : i_mem_word[31:16];

      o_load_data = i_mem_word;
      case (i_size)
         SIZE_B:  o_load_data = {{24{i_signed & w_byte[7]}}, w_byte};
         SIZE_H:  o_load_data = {{16{i_signed & w_half[15]}}, w_half};
         default: o_load_data = i_mem_word;
      endcase
   end

   always_comb begin
      o_merge_word = i_mem_word;
      case (i_size)
         SIZE_B: begin
            case (i_offset)
               2'd0:    o_merge_word[31:24] = i_wdata[7:0];
               2'd1:    o_merge_word[23:16] = i_wdata[7:0];
               2'd2:    o_merge_word[15:8]  = i_wdata[7:0];
               default: o_merge_word[7:0]   = i_wdata[7:0];
            endcase
         end
         SIZE_H: begin
            if (i_offset[1]) o_merge_word[15:0]  = i_wdata[15:0];
            else             o_merge_word[31:16] = i_wdata[15:0];
         end
         default: o_merge_word = i_wdata;
      endcase
   end

endmodule

// File: rtl/mem_ls_unit.sv
// Load/store unit: one request at a time, sub-word stores as read-modify-write,
// one-cycle response pulse. Strobes and outputs decode straight from the state.
module mem_ls_unit
   import mem_ls_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [31:0] mem_read_data,
   output logic [2:0]  o_dbg_state
);

   // Handshake: a request transfers on a rising edge where req_valid and
   // req_ready are both high; req_ready is high only in IDLE, and request
   // inputs are ignored in every other cycle.
   logic [2:0]  r_state;
   logic [2:0]  w_state_nxt;
   ls_req_t     r_req;
   logic [31:0] r_merge;
   logic [31:0] r_rdata;
   logic        w_accept;
   logic        w_legal;
   logic        w_mem_active;
   logic [31:0] w_load_data;
   logic [31:0] w_merge_word;

   assign w_accept = req_valid & (r_state == ST_IDLE);
   assign w_legal  = req_legal(req_size, req_addr[1:0]);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               if (!w_legal)                w_state_nxt = ST_ERR;
               else if (!req_write)         w_state_nxt = ST_LOAD;
               else if (req_size == SIZE_W) w_state_nxt = ST_STORE;
               else                         w_state_nxt = ST_RMW_RD;
            end
         end
         ST_LOAD:   w_state_nxt = ST_RESP;
         ST_STORE:  w_state_nxt = ST_RESP;
         ST_RMW_RD: w_state_nxt = ST_RMW_WR;
         ST_RMW_WR: w_state_nxt = ST_RESP;
         ST_RESP:   w_state_nxt = ST_IDLE;
         ST_ERR:    w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   ls_lane_align u_align (
      .i_mem_word   (mem_read_data),
      .i_wdata      (r_req.wdata),
      .i_offset     (r_req.addr[1:0]),
      .i_size       (r_req.size),
      .i_signed     (r_req.sgn),
      .o_load_data  (w_load_data),
      .o_merge_word (w_merge_word)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_req   <= '0;
         r_merge <= WORD_ZERO;
         r_rdata <= WORD_ZERO;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_req <= '{size: req_size, sgn: req_signed, addr: req_addr, wdata: req_wdata};
         end
         // mem_read_data is only meaningful while mem_read is high, so it is
         // captured solely in LOAD and RMW_RD.
         case (r_state)
            ST_IDLE: begin
               if (w_accept && !w_legal) r_rdata <= WORD_ZERO;
            end
            ST_LOAD:             r_rdata <= w_load_data;
            ST_STORE, ST_RMW_WR: r_rdata <= WORD_ZERO;
            ST_RMW_RD:           r_merge <= w_merge_word;
            default: ;
         endcase
      end
   end

   assign req_ready    = (r_state == ST_IDLE);
   assign resp_valid   = (r_state == ST_RESP) | (r_state == ST_ERR);
   assign resp_err     = (r_state == ST_ERR);
   assign resp_rdata   = r_rdata;
   assign mem_read     = (r_state == ST_LOAD) | (r_state == ST_RMW_RD);
   assign mem_write    = (r_state == ST_STORE) | (r_state == ST_RMW_WR);
   assign w_mem_active = mem_read | mem_write;
   assign mem_address  = w_mem_active ? {r_req.addr[31:2], 2'b00} : WORD_ZERO;
   assign o_dbg_state  = r_state;

   always_comb begin
      mem_write_data = WORD_ZERO;
      if (r_state == ST_STORE)       mem_write_data = r_req.wdata;
      else if (r_state == ST_RMW_WR) mem_write_data = r_merge;
   end

endmodule

// File: tb/tb_mem_ls_unit.sv
// Bench for mem_ls_unit: a small data_mem model, a driver, and a monitor that
// checks responses and memory writes against a reference model's queues.
module tb_mem_ls_unit;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic        mem_read;
   logic        mem_write;
   wire  [31:0] mem_read_data;
   logic [2:0]  o_dbg_state;

   mem_ls_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_write      (req_write),
      .req_size       (req_size),
      .req_signed     (req_signed),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .resp_valid     (resp_valid),
      .resp_err       (resp_err),
      .resp_rdata     (resp_rdata),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .mem_read_data  (mem_read_data),
      .o_dbg_state    (o_dbg_state)
   );

   // ---------------- clock / reset / data_mem model ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] mem [0:15];
   logic        pl_en;
   logic [3:0]  pl_idx;
   logic [31:0] pl_data;

   always @(posedge clk) begin
      if (pl_en)          mem[pl_idx] <= pl_data;
      else if (mem_write) mem[mem_address[5:2]] <= mem_write_data;
   end
   assign mem_read_data = mem_read ? mem[mem_address[5:2]] : 32'hzzzz_zzzz;

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int errors = 0;
   logic [31:0] ref_mem [0:15];
   logic [32:0] exp_q[$];
   int          exp_cyc_q[$];
   logic [63:0] wr_q[$];
   int          rd_cnt = 0;
   int          wr_cnt = 0;
   int          resp_cnt = 0;
   logic [31:0] last_rdata = 32'h0;
   logic        last_err = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference behaviour from the access rules, using shifts and masks.
   function automatic void model(input logic w, input logic [1:0] sz, input logic sgn,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 output logic err, output logic [31:0] rdata, output int lat,
                                 output logic wr, output logic [31:0] wr_word);
      int nbytes;
      int off;
      int sh;
      logic [31:0] mask;
      logic [31:0] old;
      logic [31:0] v;
      off     = int'(a[1:0]);
      old     = ref_mem[a[5:2]];
      err     = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && off != 0);
      rdata   = 32'h0;
      wr      = 1'b0;
      wr_word = 32'h0;
      lat     = 1;
      if (!err) begin
         nbytes = 1 << sz;
         sh     = (4 - nbytes - off) * 8;
         mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 32'h1);
         if (!w) begin
            v = (old >> sh) & mask;
            if (sgn && nbytes < 4 && v[8 * nbytes - 1]) v = v | ~mask;
            rdata = v;
            lat   = 2;
         end else begin
            wr      = 1'b1;
            wr_word = (old & ~(mask << sh)) | ((wd & mask) << sh);
            lat     = (nbytes == 4) ? 2 : 3;
         end
      end
   endfunction

   // ---------------- driver tasks (called at a falling edge) ----------------
   task automatic preload(input logic [31:0] a, input logic [31:0] d);
      pl_en   = 1'b1;
      pl_idx  = a[5:2];
      pl_data = d;
      ref_mem[a[5:2]] = d;
      @(posedge clk);
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   task automatic issue(input logic w, input logic [1:0] sz, input logic sgn,
                        input logic [31:0] a, input logic [31:0] wd, output int acc);
      logic err;
      logic [31:0] rd;
      int lat;
      logic wr;
      logic [31:0] ww;
      int n;
      req_valid  = 1'b1;
      req_write  = w;
      req_size   = sz;
      req_signed = sgn;
      req_addr   = a;
      req_wdata  = wd;
      n = 0;
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got req_ready=0 expected 1 within 100 cycles");
         req_valid = 1'b0;
         acc = -1;
         return;
      end
      model(w, sz, sgn, a, wd, err, rd, lat, wr, ww);
      if (wr) begin
         ref_mem[a[5:2]] = ww;
         wr_q.push_back({a[31:2], 2'b00, ww});
      end
      exp_q.push_back({err, rd});
      exp_cyc_q.push_back(cyc + lat);
      acc = cyc;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_drain();
      int n;
      req_valid = 1'b0;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: got %0d pending responses expected 0", exp_q.size());
         exp_q.delete();
         exp_cyc_q.delete();
      end
      @(negedge clk);
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic [32:0] e;
      logic [63:0] we;
      int ec;
      forever begin
         @(negedge clk);
         if (mem_read || mem_write) begin
            checks++;
            if ((mem_read && mem_write) || mem_address[1:0] != 2'b00) begin
               errors++;
               $display("FAIL strobe_sanity: got rd=%b wr=%b addr=%h expected exclusive strobes, aligned addr",
                        mem_read, mem_write, mem_address);
            end
            if (mem_read)  rd_cnt++;
            if (mem_write) wr_cnt++;
         end
         if (mem_write) begin
            checks++;
            if (wr_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write: got addr=%h data=%h expected no write", mem_address, mem_write_data);
            end else begin
               we = wr_q.pop_front();
               if ({mem_address, mem_write_data} !== we) begin
                  errors++;
                  $display("FAIL mem_write: got %h/%h expected %h/%h",
                           mem_address, mem_write_data, we[63:32], we[31:0]);
               end
            end
         end
         if (resp_valid) begin
            resp_cnt++;
            last_rdata = resp_rdata;
            last_err   = resp_err;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_resp: got err=%b rdata=%h expected none", resp_err, resp_rdata);
            end else begin
               e  = exp_q.pop_front();
               ec = exp_cyc_q.pop_front();
               if ({resp_err, resp_rdata} !== e) begin
                  errors++;
                  $display("FAIL resp_data: got err=%b rdata=%h expected err=%b rdata=%h",
                           resp_err, resp_rdata, e[32], e[31:0]);
               end
               checks++;
               if (cyc != ec) begin
                  errors++;
                  $display("FAIL resp_latency: got cycle %0d expected %0d", cyc, ec);
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int acc;
      int acc2;
      int rd0;
      int wr0;
      int rc0;
      int n;
      logic        w;
      logic [1:0]  sz;
      logic [31:0] a;

      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_size   = 2'b00;
      req_signed = 1'b0;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      pl_en      = 1'b0;
      pl_idx     = 4'h0;
      pl_data    = 32'h0;
      repeat (2) @(negedge clk);

      chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
      chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
      chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
      chk("rst_resp_rdata", resp_rdata, 32'h0);
      chk("rst_mem_address", mem_address, 32'h0);
      chk("rst_mem_write_data", mem_write_data, 32'h0);
      chk("rst_mem_strobes", {30'h0, mem_read, mem_write}, 32'h0);
      chk("rst_state", {29'h0, o_dbg_state}, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 16; i++) preload(32'h100 + 32'(i * 4), $urandom);

      // Byte loads
      preload(32'h100, 32'h8122_3344);
      issue(1'b0, 2'b00, 1'b1, 32'h100, 32'h0, acc);
      wait_drain();
      chk("lb_0x100", last_rdata, 32'hFFFF_FF81);
      issue(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, acc);
      wait_drain();
      chk("lbu_0x100", last_rdata, 32'h0000_0081);
      issue(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, acc);
      wait_drain();
      chk("lb_0x103", last_rdata, 32'h0000_0044);

      // Byte store through read-modify-write
      preload(32'h100, 32'h1122_3344);
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      issue(1'b1, 2'b00, 1'b0, 32'h101, 32'h0000_00AB, acc);
      wait_drain();
      chk("sb_read_cycles", 32'(rd_cnt - rd0), 32'd1);
      chk("sb_write_cycles", 32'(wr_cnt - wr0), 32'd1);
      chk("sb_mem", mem[0], 32'h11AB_3344);
      chk("sb_rdata_zero", last_rdata, 32'h0);

      // Half store then loads
      preload(32'h100, 32'h1122_3344);
      issue(1'b1, 2'b01, 1'b0, 32'h102, 32'h0000_BEEF, acc);
      wait_drain();
      chk("sh_mem", mem[0], 32'h1122_BEEF);
      issue(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, acc);
      wait_drain();
      chk("lh_0x102", last_rdata, 32'hFFFF_BEEF);
      issue(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, acc);
      wait_drain();
      chk("lhu_0x102", last_rdata, 32'h0000_BEEF);

      // Errors: no strobes, one-cycle latency checked by the monitor
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      issue(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, acc);
      wait_drain();
      chk("lw_mis_err", {31'h0, last_err}, 32'h1);
      issue(1'b1, 2'b01, 1'b0, 32'h101, 32'h1234, acc);
      wait_drain();
      chk("sh_mis_err", {31'h0, last_err}, 32'h1);
      issue(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, acc);
      wait_drain();
      chk("size3_err", {31'h0, last_err}, 32'h1);
      chk("err_rdata_zero", last_rdata, 32'h0);
      chk("err_no_strobes", 32'((rd_cnt - rd0) + (wr_cnt - wr0)), 32'd0);

      // Reset during the RMW write cycle
      preload(32'h100, 32'h1122_3344);
      rc0 = resp_cnt;
      req_valid  = 1'b1;
      req_write  = 1'b1;
      req_size   = 2'b00;
      req_signed = 1'b0;
      req_addr   = 32'h101;
      req_wdata  = 32'h0000_00AB;
      wr_q.push_back({32'h100, 32'h11AB_3344});
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (!mem_write && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("rmw_wr_reached", {31'h0, mem_write}, 32'h1);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_drops_mem_write", {31'h0, mem_write}, 32'h0);
      chk("rst_forces_idle", {29'h0, o_dbg_state}, 32'h0);
      repeat (2) @(negedge clk);
      chk("rst_mem_unchanged", mem[0], 32'h1122_3344);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_ready_after", {31'h0, req_ready}, 32'h1);
      chk("rst_no_resp", 32'(resp_cnt - rc0), 32'd0);
      chk("rst_mem_still", mem[0], 32'h1122_3344);

      // Back-to-back: hold req_valid across sw then lw
      issue(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF, acc);
      issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, acc2);
      wait_drain();
      chk("b2b_accept_gap", 32'(acc2 - acc), 32'd3);
      chk("b2b_lw", last_rdata, 32'hDEAD_BEEF);

      // Randomised mix against the reference model
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            req_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
         end
         w  = 1'($urandom_range(0, 1));
         sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         a  = 32'h100 + 32'($urandom_range(0, 63));
         if ($urandom_range(0, 9) < 7) begin
            if (sz == 2'b01) a[0] = 1'b0;
            if (sz == 2'b10) a[1:0] = 2'b00;
         end
         issue(w, sz, 1'($urandom_range(0, 1)), a, $urandom, acc);
      end
      wait_drain();
      for (int i = 0; i < 16; i++) chk($sformatf("final_mem_%0d", i), mem[i], ref_mem[i]);
      chk("wr_q_empty", 32'(wr_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
